// File: rtl/face_blink_ctrl.sv
// rtl/face_blink_ctrl.sv - Alternating A/B face select sequencer with prescaled hold time
// Three-process FSM; every output is a register fed from the current state.
module face_blink_ctrl #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned BLINKS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic       select,
  output logic       busy,
  output logic       done,
  output logic [3:0] blink_cnt
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    CNT_LAST = 4'(BLINKS - 1);

  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          select_q, select_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    blink_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      select_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      select_q    <= select_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      blink_cnt_q <= cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        pre_d = '0;
        if (start && !stop) begin
          state_d = SHOW_A;
          cnt_d   = '0;
        end
      end
      SHOW_A: begin
        if (stop) begin
          state_d = IDLE;
          pre_d   = '0;
        end else if (pre_q == PRE_LAST) begin
          state_d = SHOW_B;
          pre_d   = '0;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      SHOW_B: begin
        if (stop) begin
          state_d = IDLE;
          pre_d   = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d   = '0;
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q == CNT_LAST) ? DONE : SHOW_A;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        pre_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // An abort clears select/busy on the same edge that leaves the show states.
  always_comb begin
    select_d = (state_q == SHOW_B) && !stop;
    busy_d   = ((state_q == SHOW_A) || (state_q == SHOW_B)) && !stop;
    done_d   = (state_q == DONE);
  end

  assign select    = select_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign blink_cnt = blink_cnt_q;

endmodule

// File: tb/tb_face_blink_ctrl.sv
// tb/tb_face_blink_ctrl.sv - Randomized and directed bench for face_blink_ctrl
module tb_face_blink_ctrl;

  localparam int T = 4;
  localparam int B = 2;
  localparam int L = 2 * T * B;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       select;
  logic       busy;
  logic       done;
  logic [3:0] blink_cnt;

  int checks = 0;
  int errors = 0;

  // Sequence position model: -1 idle, 0..L-1 showing faces, L = completion cycle.
  int pos = -1;
  int held = 0;

  face_blink_ctrl #(.TICK_DIV(T), .BLINKS(B)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .select(select), .busy(busy), .done(done), .blink_cnt(blink_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic sp);
    int e_sel, e_busy, e_done, e_cnt;
    start = st;
    stop  = sp;
    @(posedge clk);
    e_sel  = (pos >= 0 && pos < L && ((pos / T) % 2 == 1) && !sp) ? 1 : 0;
    e_busy = (pos >= 0 && pos < L && !sp) ? 1 : 0;
    e_done = (pos == L) ? 1 : 0;
    e_cnt  = held;
    if (pos == -1) begin
      if (st && !sp) begin
        pos  = 0;
        held = 0;
      end
    end else if (pos == L || sp) begin
      pos = -1;
    end else begin
      pos++;
      held = pos / (2 * T);
    end
    #1;
    check("select", select, e_sel);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("blink_cnt", blink_cnt, e_cnt);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_select", select, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_blink_cnt", blink_cnt, 0);
    pos  = -1;
    held = 0;
    #2 rst = 1'b1;
  endtask

  initial begin
    int first_done;
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_select", select, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_blink_cnt", blink_cnt, 0);
    #3 rst = 1'b1;

    // Normal run with a latency measurement on the done pulse
    first_done = -1;
    step(1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0);
      if (done === 1'b1 && first_done < 0) first_done = k;
    end
    check("latency", first_done, L + 1);

    // Abort at E+6
    step(1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);

    // start/stop collision
    step(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);

    // Extra start pulse at E+3 is ignored
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b0);

    // Auto-repeat with start held high
    for (int k = 0; k < 24; k++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Asynchronous reset during SHOW_B
    step(1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) step(1'b0, 1'b0);
    async_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);

    // Randomized traffic with occasional stop and mid-cycle reset
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
